// File: rtl/matrix_pkg.sv
// Shared constants and loader state encoding for the matrix multiplier,
// the matrix dump block and the matrix_reader loader.
package matrix_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/byte_assembler.sv
// Packs big-endian bytes into 32-bit words; word_valid_o pulses combinationally
// with the accepted byte that completes a word, and word_o carries that word.
module byte_assembler
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    logic [WORD_W-BYTE_W-1:0] acc_q, acc_d;
    logic [BCNT_W-1:0]        cnt_q, cnt_d;

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        word_valid_o = 1'b0;
        // Only the three older bytes are stored; the fourth comes straight from the input.
        word_o       = {acc_q, byte_i};
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (valid_i) begin
            acc_d = {acc_q[WORD_W-2*BYTE_W-1:0], byte_i};
            if (cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
                cnt_d        = '0;
                word_valid_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matrix_reader.sv
// Loads an N x N matrix of 32-bit words from a big-endian byte stream and emits
// addressed word writes. Define MATRIX_READER_TRANSPOSE_EN to store the transpose.
module matrix_reader
    import matrix_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_row,
    output logic [IDX_W-1:0]  wr_col,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0]   wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic [WORD_W-1:0]  wr_data_q, wr_data_d;
    logic               wr_en_q, wr_en_d;
    logic               accept, clear, word_valid;
    logic [WORD_W-1:0]  word;
    logic               last_col, last_row;

    // Handshake outputs decode the state register only, so in_valid never reaches in_ready.
    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q == S_LOAD);
    assign done     = (state_q == S_DONE);
    assign accept   = in_valid && in_ready;
    assign clear    = start && (state_q != S_LOAD);
    assign last_col = (col_q == IDX_W'(N - 1));
    assign last_row = (row_q == IDX_W'(N - 1));

    assign wr_en   = wr_en_q;
    assign wr_row  = wr_row_q;
    assign wr_col  = wr_col_q;
    assign wr_data = wr_data_q;

    byte_assembler u_byte_assembler (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .valid_i      (accept),
        .byte_i       (in_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        wr_en_d   = 1'b0;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = word;
`ifdef MATRIX_READER_TRANSPOSE_EN
                    wr_row_d  = col_q;
                    wr_col_d  = row_q;
`else
                    wr_row_d  = row_q;
                    wr_col_d  = col_q;
`endif
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_matrix_reader.sv
// Self-checking bench: an N=2 and an N=8 loader driven with byte streams and
// compared against a placement model computed from the stream bytes.
module tb_matrix_reader;

    localparam int NA  = 2;
    localparam int NB  = 8;
    localparam int IWA = $clog2(NA) + 1;
    localparam int IWB = $clog2(NB) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           a_start, a_valid, a_ready, a_wr_en, a_busy, a_done;
    logic [7:0]     a_byte;
    logic [IWA-1:0] a_row, a_col;
    logic [31:0]    a_data;
    logic           b_start, b_valid, b_ready, b_wr_en, b_busy, b_done;
    logic [7:0]     b_byte;
    logic [IWB-1:0] b_row, b_col;
    logic [31:0]    b_data;

    matrix_reader #(.N(NA)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .in_byte(a_byte), .in_valid(a_valid),
        .in_ready(a_ready), .wr_en(a_wr_en), .wr_row(a_row), .wr_col(a_col),
        .wr_data(a_data), .busy(a_busy), .done(a_done)
    );

    matrix_reader #(.N(NB)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in_byte(b_byte), .in_valid(b_valid),
        .in_ready(b_ready), .wr_en(b_wr_en), .wr_row(b_row), .wr_col(b_col),
        .wr_data(b_data), .busy(b_busy), .done(b_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [7:0]  stim[$];
    logic [31:0] a_q_data[$], b_q_data[$];
    int          a_q_row[$], a_q_col[$], a_q_cyc[$];
    int          b_q_row[$], b_q_col[$];
    int          a_busy_cnt = 0;
    int          a_done_cyc = -1;
    logic        a_done_prev = 1'b0;
    logic        a_ready_at_done = 1'b1;

    always @(negedge clk) begin
        if (a_wr_en) begin
            a_q_data.push_back(a_data);
            a_q_row.push_back(int'(a_row));
            a_q_col.push_back(int'(a_col));
            a_q_cyc.push_back(cycle);
        end
        if (b_wr_en) begin
            b_q_data.push_back(b_data);
            b_q_row.push_back(int'(b_row));
            b_q_col.push_back(int'(b_col));
        end
        if (a_busy) a_busy_cnt++;
        if (a_done && !a_done_prev) begin
            a_done_cyc      = cycle;
            a_ready_at_done = a_ready;
        end
        a_done_prev = a_done;
    end

    // Reference placement: element k is bytes 4k..4k+3 MSB first, row-major in the stream.
    function automatic logic [31:0] model_word(int k);
        return {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
    endfunction

    function automatic int model_row(int k, int n);
`ifdef MATRIX_READER_TRANSPOSE_EN
        return k % n;
`else
        return k / n;
`endif
    endfunction

    function automatic int model_col(int k, int n);
`ifdef MATRIX_READER_TRANSPOSE_EN
        return k / n;
`else
        return k % n;
`endif
    endfunction

    task automatic clear_a_log();
        a_q_data.delete(); a_q_row.delete(); a_q_col.delete(); a_q_cyc.delete();
        a_busy_cnt = 0;
        a_done_cyc = -1;
    endtask

    task automatic start_a();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic start_b();
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
    endtask

    // mode 0: continuous valid, 1: valid toggles 1/0, 2: random gaps
    task automatic feed_a(input int first, input int cnt, input int mode);
        for (int i = first; i < first + cnt; i++) begin
            int waitc = 0;
            a_valid = 1'b1;
            a_byte  = stim[i];
            while (!a_ready && waitc < 20) begin
                @(posedge clk); #1;
                waitc++;
            end
            if (!a_ready) begin
                n_checks++; n_fail++;
                $display("FAIL feed_a_timeout: in_ready=%0b required 1 at byte %0d", a_ready, i);
                a_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            a_valid = 1'b0;
            if (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic feed_b(input int cnt, input int mode);
        for (int i = 0; i < cnt; i++) begin
            int waitc = 0;
            b_valid = 1'b1;
            b_byte  = stim[i];
            while (!b_ready && waitc < 20) begin
                @(posedge clk); #1;
                waitc++;
            end
            if (!b_ready) begin
                n_checks++; n_fail++;
                $display("FAIL feed_b_timeout: in_ready=%0b required 1 at byte %0d", b_ready, i);
                b_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            b_valid = 1'b0;
            if (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        n_checks++;
        if ({a_ready, a_wr_en, a_busy, a_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_a_ctrl: ready/wr_en/busy/done=%b required 0000",
                     {a_ready, a_wr_en, a_busy, a_done});
        end
        n_checks++;
        if (a_row !== '0 || a_col !== '0 || a_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_a_data: row=%0d col=%0d data=%h required 0 0 0",
                     a_row, a_col, a_data);
        end
        n_checks++;
        if ({b_ready, b_wr_en, b_busy, b_done} !== 4'b0 || b_data !== 32'h0 ||
            b_row !== '0 || b_col !== '0) begin
            n_fail++;
            $display("FAIL reset_b: ctrl=%b row=%0d col=%0d data=%h required all 0",
                     {b_ready, b_wr_en, b_busy, b_done}, b_row, b_col, b_data);
        end
        rst = 1'b0;
        wait_cycles(1);
    endtask

    task automatic test_back_to_back();
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(8'(i));
        clear_a_log();
        start_a();
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_after_start: in_ready=%0b required 1", a_ready);
        end
        feed_a(0, 16, 0);
        wait_cycles(3);
        n_checks++;
        if (a_q_data.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_write_count: got %0d required 4", a_q_data.size());
        end
        for (int k = 0; k < a_q_data.size() && k < 4; k++) begin
            n_checks++;
            if (a_q_data[k] !== model_word(k) || a_q_row[k] != model_row(k, NA) ||
                a_q_col[k] != model_col(k, NA)) begin
                n_fail++;
                $display("FAIL b2b_write%0d: got (%0d,%0d)=%h required (%0d,%0d)=%h", k,
                         a_q_row[k], a_q_col[k], a_q_data[k],
                         model_row(k, NA), model_col(k, NA), model_word(k));
            end
        end
        for (int k = 1; k < a_q_cyc.size(); k++) begin
            n_checks++;
            if (a_q_cyc[k] - a_q_cyc[k-1] != 4) begin
                n_fail++;
                $display("FAIL b2b_spacing%0d: got %0d required 4", k,
                         a_q_cyc[k] - a_q_cyc[k-1]);
            end
        end
        n_checks++;
        if (a_q_cyc.size() == 0 || a_done_cyc != a_q_cyc[a_q_cyc.size()-1]) begin
            n_fail++;
            $display("FAIL b2b_done_with_last_write: done cycle %0d required last wr_en cycle",
                     a_done_cyc);
        end
        n_checks++;
        if (a_ready_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_at_done: in_ready=%0b required 0", a_ready_at_done);
        end
        n_checks++;
        if (a_busy_cnt != 16) begin
            n_fail++;
            $display("FAIL b2b_load_cycles: got %0d required 16", a_busy_cnt);
        end
        n_checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_held: done=%0b busy=%0b required 1 0", a_done, a_busy);
        end
    endtask

    task automatic test_valid_toggle();
        clear_a_log();
        start_a();
        n_checks++;
        if (a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_done_cleared: done=%0b required 0", a_done);
        end
        feed_a(0, 16, 1);
        wait_cycles(3);
        n_checks++;
        if (a_q_data.size() != 4) begin
            n_fail++;
            $display("FAIL toggle_write_count: got %0d required 4", a_q_data.size());
        end
        for (int k = 0; k < a_q_data.size() && k < 4; k++) begin
            n_checks++;
            if (a_q_data[k] !== model_word(k) || a_q_row[k] != model_row(k, NA) ||
                a_q_col[k] != model_col(k, NA)) begin
                n_fail++;
                $display("FAIL toggle_write%0d: got (%0d,%0d)=%h required (%0d,%0d)=%h", k,
                         a_q_row[k], a_q_col[k], a_q_data[k],
                         model_row(k, NA), model_col(k, NA), model_word(k));
            end
        end
        for (int k = 1; k < a_q_cyc.size(); k++) begin
            n_checks++;
            if (a_q_cyc[k] - a_q_cyc[k-1] != 8) begin
                n_fail++;
                $display("FAIL toggle_spacing%0d: got %0d required 8", k,
                         a_q_cyc[k] - a_q_cyc[k-1]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
        clear_a_log();
        start_a();
        feed_a(0, 6, 0);
        wait_cycles(1);
        n_checks++;
        if (a_q_data.size() != 1) begin
            n_fail++;
            $display("FAIL rstmid_pre_writes: got %0d required 1", a_q_data.size());
        end
        clear_a_log();
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        n_checks++;
        if ({a_ready, a_wr_en, a_busy, a_done} !== 4'b0 || a_data !== 32'h0 ||
            a_row !== '0 || a_col !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: ctrl=%b row=%0d col=%0d data=%h required all 0",
                     {a_ready, a_wr_en, a_busy, a_done}, a_row, a_col, a_data);
        end
        wait_cycles(4);
        n_checks++;
        if (a_q_data.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_write: got %0d writes required 0", a_q_data.size());
        end
        start_a();
        feed_a(0, 16, 0);
        wait_cycles(3);
        n_checks++;
        if (a_q_data.size() != 4) begin
            n_fail++;
            $display("FAIL rstmid_write_count: got %0d required 4", a_q_data.size());
        end
        for (int k = 0; k < a_q_data.size() && k < 4; k++) begin
            n_checks++;
            if (a_q_data[k] !== model_word(k) || a_q_row[k] != model_row(k, NA) ||
                a_q_col[k] != model_col(k, NA)) begin
                n_fail++;
                $display("FAIL rstmid_write%0d: got (%0d,%0d)=%h required (%0d,%0d)=%h", k,
                         a_q_row[k], a_q_col[k], a_q_data[k],
                         model_row(k, NA), model_col(k, NA), model_word(k));
            end
        end
    endtask

    task automatic test_start_ignored();
        int ready_seen;
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
        clear_a_log();
        start_a();
        feed_a(0, 8, 0);
        start_a();
        feed_a(8, 8, 0);
        wait_cycles(2);
        ready_seen = 0;
        a_valid = 1'b1;
        a_byte  = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            if (a_ready) ready_seen++;
            wait_cycles(1);
        end
        a_valid = 1'b0;
        n_checks++;
        if (ready_seen != 0) begin
            n_fail++;
            $display("FAIL ignore_ready_in_done: in_ready high %0d cycles required 0", ready_seen);
        end
        n_checks++;
        if (a_q_data.size() != 4) begin
            n_fail++;
            $display("FAIL ignore_write_count: got %0d required 4", a_q_data.size());
        end
        for (int k = 0; k < a_q_data.size() && k < 4; k++) begin
            n_checks++;
            if (a_q_data[k] !== model_word(k) || a_q_row[k] != model_row(k, NA) ||
                a_q_col[k] != model_col(k, NA)) begin
                n_fail++;
                $display("FAIL ignore_write%0d: got (%0d,%0d)=%h required (%0d,%0d)=%h", k,
                         a_q_row[k], a_q_col[k], a_q_data[k],
                         model_row(k, NA), model_col(k, NA), model_word(k));
            end
        end
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
        clear_a_log();
        start_a();
        feed_a(0, 16, 2);
        wait_cycles(3);
        n_checks++;
        if (a_q_data.size() != 4 || a_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_count: got %0d writes done=%0b required 4 1",
                     a_q_data.size(), a_done);
        end
        for (int k = 0; k < a_q_data.size() && k < 4; k++) begin
            n_checks++;
            if (a_q_data[k] !== model_word(k) || a_q_row[k] != model_row(k, NA) ||
                a_q_col[k] != model_col(k, NA)) begin
                n_fail++;
                $display("FAIL reload_write%0d: got (%0d,%0d)=%h required (%0d,%0d)=%h", k,
                         a_q_row[k], a_q_col[k], a_q_data[k],
                         model_row(k, NA), model_col(k, NA), model_word(k));
            end
        end
    endtask

    task automatic test_random_n8();
        int last;
        stim.delete();
        for (int i = 0; i < 4 * NB * NB; i++) stim.push_back(8'($urandom));
        b_q_data.delete(); b_q_row.delete(); b_q_col.delete();
        start_b();
        feed_b(4 * NB * NB, 2);
        wait_cycles(3);
        n_checks++;
        if (b_q_data.size() != NB * NB) begin
            n_fail++;
            $display("FAIL n8_write_count: got %0d required %0d", b_q_data.size(), NB * NB);
        end
        for (int k = 0; k < b_q_data.size() && k < NB * NB; k++) begin
            n_checks++;
            if (b_q_data[k] !== model_word(k) || b_q_row[k] != model_row(k, NB) ||
                b_q_col[k] != model_col(k, NB)) begin
                n_fail++;
                $display("FAIL n8_write%0d: got (%0d,%0d)=%h required (%0d,%0d)=%h", k,
                         b_q_row[k], b_q_col[k], b_q_data[k],
                         model_row(k, NB), model_col(k, NB), model_word(k));
            end
        end
        last = b_q_data.size() - 1;
        n_checks++;
        if (last < 0 || b_q_row[last] != NB - 1 || b_q_col[last] != NB - 1) begin
            n_fail++;
            $display("FAIL n8_last_pos: got (%0d,%0d) required (7,7)",
                     (last < 0) ? -1 : b_q_row[last], (last < 0) ? -1 : b_q_col[last]);
        end
        wait_cycles(10);
        n_checks++;
        if (b_done !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL n8_done_held: done=%0b in_ready=%0b required 1 0", b_done, b_ready);
        end
        start_b();
        n_checks++;
        if (b_done !== 1'b0 || b_busy !== 1'b1 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL n8_restart: done=%0b busy=%0b in_ready=%0b required 0 1 1",
                     b_done, b_busy, b_ready);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        a_start = 1'b0; a_valid = 1'b0; a_byte = 8'h0;
        b_start = 1'b0; b_valid = 1'b0; b_byte = 8'h0;
        @(posedge clk); #1;
        test_reset();
        test_back_to_back();
        test_valid_toggle();
        test_reset_mid_load();
        test_start_ignored();
        test_random_n8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
